// File: rtl/lightio_tx_scheduler.sv
// Round-robin transmit scheduler sharing one light-link encoder among N_REQ packet sources.
// Define LIGHTIO_TX_STATS_EN to add the pkt_count/err_count statistics outputs.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module lightio_tx_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned PACKET_SIZE  = `PACKET_SIZE,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*PACKET_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         enc_reset,
  output logic [PACKET_SIZE-1:0]       enc_data,
  input  logic                         enc_done,
  output logic                         busy,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic                         timeout_err
`ifdef LIGHTIO_TX_STATS_EN
  ,
  output logic [15:0]                  pkt_count,
  output logic [7:0]                   err_count
`endif
);

  localparam int unsigned IdW    = $clog2(N_REQ);
  localparam int unsigned CntMax = (TIMEOUT > GUARD_CYCLES) ? TIMEOUT : GUARD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGuard} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdW-1:0]         rr_q, rr_d;
  logic [IdW-1:0]         grant_q, grant_d;
  logic [PACKET_SIZE-1:0] data_q, data_d;
  logic                   busy_q;
  logic                   pkt_done;
  logic                   found;
  logic [IdW-1:0]         win;
  int                     idx;

  // First valid requester at or after rr_q, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = int'(rr_q) + i;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!found && req_valid[idx[IdW-1:0]]) begin
        found = 1'b1;
        win   = idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    req_ready   = '0;
    timeout_err = 1'b0;
    pkt_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          req_ready[win] = 1'b1;
          data_d         = req_data[int'(win)*PACKET_SIZE +: PACKET_SIZE];
          grant_d        = win;
          rr_d           = (int'(win) == int'(N_REQ) - 1) ? '0 : win + 1'b1;
          cnt_d          = '0;
          state_d        = StLoad;
        end
      end
      StLoad: begin
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSend: begin
        // done in the first SEND cycle is left over from the previous packet
        if (cnt_q != '0 && enc_done) begin
          pkt_done = 1'b1;
          cnt_d    = '0;
          state_d  = StGuard;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          cnt_d       = '0;
          state_d     = StGuard;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGuard: begin
        if (cnt_q == CntW'(GUARD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign enc_reset = (state_q != StSend);
  assign enc_data  = data_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

`ifdef LIGHTIO_TX_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (timeout_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_lightio_tx_scheduler.sv
// Randomized bench for lightio_tx_scheduler against a per-packet timeline model.
module tb_lightio_tx_scheduler;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int G  = 4;
  localparam int TO = 16;
  localparam int N_CYC = 5000;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*P-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           enc_reset;
  logic [P-1:0]   enc_data;
  logic           enc_done;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;
`ifdef LIGHTIO_TX_STATS_EN
  logic [15:0]    pkt_count;
  logic [7:0]     err_count;
`endif

  lightio_tx_scheduler #(
    .N_REQ       (N),
    .PACKET_SIZE (P),
    .GUARD_CYCLES(G),
    .TIMEOUT     (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .enc_reset  (enc_reset),
    .enc_data   (enc_data),
    .enc_done   (enc_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
`ifdef LIGHTIO_TX_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .err_count  (err_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: one packet is described by its accept cycle, winner, and the SEND cycle
  // from which done is held high; everything else follows by arithmetic.
  bit       in_pkt = 0;
  int       t_acc, w, d, kend, rel, k;
  bit       err;
  int       ptr = 0;
  int       m_gid = 0;
  logic [7:0] m_data = '0;
  bit       stale_next = 0;
  bit       pv[N];
  logic [7:0] pend[N];
  int       n_pkts = 0;
  int       m_pkt_cnt = 0;
  int       m_err_cnt = 0;
  bit       idle, accept, do_reset, in_send;
  logic [N-1:0] exp_ready;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    enc_done  = 1'b0;
    for (int i = 0; i < N; i++) begin
      pv[i]   = 0;
      pend[i] = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_enc_reset", enc_reset, 1);
    check_eq("rst_enc_data", enc_data, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
`ifdef LIGHTIO_TX_STATS_EN
    check_eq("rst_pkt_count", pkt_count, 0);
    check_eq("rst_err_count", err_count, 0);
`endif

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clock);
      #1;
      reset    = 1'b1;
      rel      = cyc - t_acc;
      idle     = !in_pkt || (rel >= kend + 3 + G);
      if (idle) in_pkt = 0;
      accept   = 0;
      do_reset = 0;
      in_send  = 0;
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(3) == 0) begin
          pv[i]   = 1;
          pend[i] = 8'($urandom);
        end
      end
      if (idle) begin
        enc_done = stale_next;
        for (int i = 0; i < N; i++) begin
          if (!accept && pv[(ptr + i) % N]) begin
            accept = 1;
            w      = (ptr + i) % N;
          end
        end
        if (accept) begin
          int r;
          t_acc  = cyc;
          in_pkt = 1;
          n_pkts++;
          r = $urandom_range(9);
          if (stale_next)  d = 1;
          else if (r == 0) d = TO;
          else if (r == 1) d = TO + 1 + $urandom_range(3);
          else if (r == 2) d = TO - 1;
          else             d = $urandom_range(TO - 1, 2);
          kend = (d < 2) ? 2 : d;
          err  = (kend > TO);
          if (kend > TO) kend = TO;
          stale_next = ($urandom_range(3) == 0);
          rel = 0;
        end
      end else if (rel <= 2) begin
        enc_done = (d == 1);
      end else if (rel <= kend + 2) begin
        k        = rel - 2;
        in_send  = 1;
        enc_done = (k >= d);
        if (n_pkts % 7 == 3 && k == 5 && kend > 5) do_reset = 1;
      end else begin
        enc_done = 1'($urandom_range(1));
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i]          = pv[i];
        req_data[i*P +: P]    = pend[i];
      end
      reset = !do_reset;

      @(negedge clock);
      exp_ready = '0;
      if (accept) exp_ready[w] = 1'b1;
      check_eq("req_ready", req_ready, exp_ready);
      check_eq("busy", busy, !idle);
      check_eq("enc_reset", enc_reset, !in_send);
      check_eq("timeout_err", timeout_err, in_send && err && (rel == kend + 2));
      check_eq("grant_id", grant_id, m_gid);
      check_eq("enc_data", enc_data, m_data);
`ifdef LIGHTIO_TX_STATS_EN
      check_eq("pkt_count", pkt_count, m_pkt_cnt % 65536);
      check_eq("err_count", err_count, (m_err_cnt > 255) ? 255 : m_err_cnt);
`endif

      if (accept) begin
        m_data = pend[w];
        m_gid  = w;
        ptr    = (w + 1) % N;
        pv[w]  = 0;
      end
      if (in_send && !do_reset && rel == kend + 2) begin
        if (err) m_err_cnt++;
        else     m_pkt_cnt++;
      end
      if (do_reset) begin
        in_pkt    = 0;
        ptr       = 0;
        m_gid     = 0;
        m_data    = '0;
        m_pkt_cnt = 0;
        m_err_cnt = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
